// File: rtl/router_fsm_np.sv
// Packet-sequencing control FSM for the N-port router: header decode, payload, parity and full stall,
// plus invalid-address drop, wait-for-empty timeout and a saturating dropped-packet counter.
//
// state              | meaning
// S_DECODE           | idle, waiting for a header on pkt_valid
// S_LOAD_FIRST       | header byte written to the selected FIFO
// S_LOAD_DATA        | payload bytes written
// S_LOAD_PARITY      | parity byte written
// S_CHECK_PARITY     | parity compare, internal register reset
// S_FIFO_FULL        | destination FIFO full, writes stalled
// S_LOAD_AFTER_FULL  | resume after a full stall
// S_WAIT_EMPTY       | destination FIFO not yet empty, header held
// S_DROP             | packet discarded while the source drains
module router_fsm_np #(
  parameter int NUM_PORTS    = 4,
  parameter int WAIT_TIMEOUT = 32,
  parameter int DROP_CNT_W   = 16,
  localparam int ADDR_W      = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [ADDR_W-1:0]     dest_addr,
  input  logic [NUM_PORTS-1:0]  fifo_full,
  input  logic [NUM_PORTS-1:0]  fifo_empty,
  input  logic [NUM_PORTS-1:0]  soft_reset,
  input  logic                  parity_done,
  input  logic                  low_pkt_valid,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  rst_int_reg,
  output logic                  write_enb_reg,
  output logic                  busy,
  output logic [ADDR_W-1:0]     dest_sel,
  output logic                  pkt_drop,
  output logic                  wait_timeout,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int CNT_W   = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam int TO_LAST = (WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0;

  typedef enum logic [3:0] {
    S_DECODE,
    S_LOAD_FIRST,
    S_LOAD_DATA,
    S_LOAD_PARITY,
    S_CHECK_PARITY,
    S_FIFO_FULL,
    S_LOAD_AFTER_FULL,
    S_WAIT_EMPTY,
    S_DROP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             sel_full;
  logic             sel_empty;
  logic             sel_srst;
  logic             addr_empty;
  logic             addr_bad;
  logic             timeout_hit;

  // Only the latched destination's status matters; an out-of-range address selects nothing.
  always_comb begin
    sel_full   = 1'b0;
    sel_empty  = 1'b0;
    sel_srst   = 1'b0;
    addr_empty = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (dest_sel == ADDR_W'(i)) begin
        sel_full  = fifo_full[i];
        sel_empty = fifo_empty[i];
        sel_srst  = soft_reset[i];
      end
      if (dest_addr == ADDR_W'(i)) begin
        addr_empty = fifo_empty[i];
      end
    end
  end

  assign addr_bad    = (32'(dest_addr) >= NUM_PORTS);
  assign timeout_hit = (WAIT_TIMEOUT != 0) && (wait_cnt == CNT_W'(TO_LAST));

  always_comb begin
    state_nxt = state;
    case (state)
      S_DECODE: begin
        if (pkt_valid) begin
          if (addr_bad)        state_nxt = S_DROP;
          else if (addr_empty) state_nxt = S_LOAD_FIRST;
          else                 state_nxt = S_WAIT_EMPTY;
        end
      end
      S_LOAD_FIRST:   state_nxt = S_LOAD_DATA;
      S_LOAD_DATA: begin
        if (sel_full)        state_nxt = S_FIFO_FULL;
        else if (!pkt_valid) state_nxt = S_LOAD_PARITY;
      end
      S_LOAD_PARITY:  state_nxt = S_CHECK_PARITY;
      S_CHECK_PARITY: state_nxt = sel_full ? S_FIFO_FULL : S_DECODE;
      S_FIFO_FULL: begin
        if (!sel_full) state_nxt = S_LOAD_AFTER_FULL;
      end
      S_LOAD_AFTER_FULL: begin
        if (parity_done)        state_nxt = S_DECODE;
        else if (low_pkt_valid) state_nxt = S_LOAD_PARITY;
        else                    state_nxt = S_LOAD_DATA;
      end
      S_WAIT_EMPTY: begin
        if (sel_empty)        state_nxt = S_LOAD_FIRST;
        else if (timeout_hit) state_nxt = S_DROP;
      end
      S_DROP: begin
        if (!pkt_valid) state_nxt = S_DECODE;
      end
      default: state_nxt = S_DECODE;
    endcase
    if (sel_srst && (state != S_DECODE)) state_nxt = S_DECODE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_DECODE;
      dest_sel     <= '0;
      wait_cnt     <= '0;
      drop_count   <= '0;
      wait_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_DECODE) && pkt_valid) dest_sel <= dest_addr;
      // Held at zero outside the wait state, so every entry starts from zero.
      if (state == S_WAIT_EMPTY) wait_cnt <= wait_cnt + 1'b1;
      else                       wait_cnt <= '0;
      wait_timeout <= (state == S_WAIT_EMPTY) && (state_nxt == S_DROP);
      if ((state_nxt == S_DROP) && (state != S_DROP) && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b0;
    pkt_drop      = 1'b0;
    case (state)
      S_DECODE:          detect_add = 1'b1;
      S_LOAD_FIRST: begin
        lfd_state = 1'b1;
        busy      = 1'b1;
      end
      S_LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
      end
      S_LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      S_CHECK_PARITY: begin
        rst_int_reg = 1'b1;
        busy        = 1'b1;
      end
      S_FIFO_FULL: begin
        full_state = 1'b1;
        busy       = 1'b1;
      end
      S_LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b1;
      end
      S_WAIT_EMPTY:      busy = 1'b1;
      S_DROP:            pkt_drop = 1'b1;
      default:           detect_add = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_router_fsm_np.sv
// Bench for router_fsm_np: a 4-port/timeout-8 instance and a 3-port/2-bit-counter instance share stimulus
// and are compared every cycle against a packet-phase reference model, plus directed scenario checks.
module tb_router_fsm_np;

  localparam int P_DEC = 0, P_LFD = 1, P_LD = 2, P_LP = 3, P_CPE = 4;
  localparam int P_FULL = 5, P_LAF = 6, P_WAIT = 7, P_DROP = 8;
  // Bit positions in the packed output vector {detect_add,lfd,ld,laf,full,rst_int,we,busy,pkt_drop}
  localparam int B_DA = 8, B_LFD = 7, B_LD = 6, B_LAF = 5, B_FULL = 4, B_WE = 2, B_BUSY = 1;

  typedef struct {
    int ph;
    int dsel;
    int wcnt;
    int dcnt;
    bit wto;
  } mdl_t;

  logic       clk = 1'b0;
  logic       resetn, pkt_valid, parity_done, low_pkt_valid;
  logic [1:0] dest_addr;
  logic [3:0] fifo_full, fifo_empty, soft_reset;
  logic [8:0] ov_a, ov_b;
  logic [1:0] ds_a, ds_b;
  logic       wto_a, wto_b;
  logic [15:0] dc_a;
  logic [1:0] dc_b;

  int   checks = 0;
  int   errors = 0;
  int   we_a, we_b, full_a, busy_a, n_wait;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  router_fsm_np #(.NUM_PORTS(4), .WAIT_TIMEOUT(8), .DROP_CNT_W(16)) dut_a (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .dest_addr(dest_addr),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(ov_a[8]), .lfd_state(ov_a[7]), .ld_state(ov_a[6]), .laf_state(ov_a[5]),
    .full_state(ov_a[4]), .rst_int_reg(ov_a[3]), .write_enb_reg(ov_a[2]), .busy(ov_a[1]),
    .dest_sel(ds_a), .pkt_drop(ov_a[0]), .wait_timeout(wto_a), .drop_count(dc_a));

  router_fsm_np #(.NUM_PORTS(3), .WAIT_TIMEOUT(5), .DROP_CNT_W(2)) dut_b (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .dest_addr(dest_addr),
    .fifo_full(fifo_full[2:0]), .fifo_empty(fifo_empty[2:0]), .soft_reset(soft_reset[2:0]),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(ov_b[8]), .lfd_state(ov_b[7]), .ld_state(ov_b[6]), .laf_state(ov_b[5]),
    .full_state(ov_b[4]), .rst_int_reg(ov_b[3]), .write_enb_reg(ov_b[2]), .busy(ov_b[1]),
    .dest_sel(ds_b), .pkt_drop(ov_b[0]), .wait_timeout(wto_b), .drop_count(dc_b));

  function automatic logic [8:0] outv(input int ph);
    case (ph)
      P_DEC:   return 9'b100000000;
      P_LFD:   return 9'b010000010;
      P_LD:    return 9'b001000100;
      P_LP:    return 9'b000000110;
      P_CPE:   return 9'b000001010;
      P_FULL:  return 9'b000010010;
      P_LAF:   return 9'b000100110;
      P_WAIT:  return 9'b000000010;
      default: return 9'b000000001;
    endcase
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m.ph = P_DEC; m.dsel = 0; m.wcnt = 0; m.dcnt = 0; m.wto = 1'b0;
    return m;
  endfunction

  // One clock of packet-phase progress, from the current input values; wcnt = cycles already spent waiting.
  function automatic mdl_t mstep(input mdl_t m, input int np, input int to, input int dmax);
    mdl_t n = m;
    int   nx = m.ph;
    bit   f = (m.dsel < np) ? fifo_full[m.dsel] : 1'b0;
    bit   e = (m.dsel < np) ? fifo_empty[m.dsel] : 1'b0;
    bit   s = (m.dsel < np) ? soft_reset[m.dsel] : 1'b0;
    int   da = int'(dest_addr);
    n.wto = 1'b0;
    if (m.ph != P_DEC && s) nx = P_DEC;
    else if (m.ph == P_DEC) begin
      if (pkt_valid) begin
        n.dsel = da;
        if (da >= np)            nx = P_DROP;
        else if (fifo_empty[da]) nx = P_LFD;
        else                     nx = P_WAIT;
      end
    end
    else if (m.ph == P_LFD) nx = P_LD;
    else if (m.ph == P_LD)  nx = f ? P_FULL : (!pkt_valid ? P_LP : P_LD);
    else if (m.ph == P_LP)  nx = P_CPE;
    else if (m.ph == P_CPE) nx = f ? P_FULL : P_DEC;
    else if (m.ph == P_FULL) nx = f ? P_FULL : P_LAF;
    else if (m.ph == P_LAF) nx = parity_done ? P_DEC : (low_pkt_valid ? P_LP : P_LD);
    else if (m.ph == P_WAIT) begin
      if (e) nx = P_LFD;
      else if (to != 0 && m.wcnt + 1 == to) begin
        nx = P_DROP;
        n.wto = 1'b1;
      end
    end
    else if (m.ph == P_DROP && !pkt_valid) nx = P_DEC;
    n.wcnt = (m.ph == P_WAIT) ? m.wcnt + 1 : 0;
    if (nx == P_DROP && m.ph != P_DROP && m.dcnt < dmax) n.dcnt = m.dcnt + 1;
    n.ph = nx;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    ma = mstep(ma, 4, 8, 65535);
    mb = mstep(mb, 3, 5, 3);
    @(posedge clk);
    #1;
    chk("a_outputs", 32'(ov_a), 32'(outv(ma.ph)));
    chk("a_dest_sel", 32'(ds_a), ma.dsel);
    chk("a_wait_timeout", 32'(wto_a), 32'(ma.wto));
    chk("a_drop_count", 32'(dc_a), ma.dcnt);
    chk("b_outputs", 32'(ov_b), 32'(outv(mb.ph)));
    chk("b_dest_sel", 32'(ds_b), mb.dsel);
    chk("b_wait_timeout", 32'(wto_b), 32'(mb.wto));
    chk("b_drop_count", 32'(dc_b), mb.dcnt);
    we_a   += int'(ov_a[B_WE]);
    we_b   += int'(ov_b[B_WE]);
    full_a += int'(ov_a[B_FULL]);
    busy_a += int'(ov_a[B_BUSY]);
  endtask

  // Asserts reset mid-cycle and checks that outputs fall back without waiting for a clock edge.
  task automatic async_reset(input string tag);
    #2;
    resetn = 1'b0;
    #1;
    chk({tag, "_a_outputs"}, 32'(ov_a), 32'(outv(P_DEC)));
    chk({tag, "_a_drop_count"}, 32'(dc_a), 0);
    chk({tag, "_b_outputs"}, 32'(ov_b), 32'(outv(P_DEC)));
    chk({tag, "_b_drop_count"}, 32'(dc_b), 0);
    ma = mreset();
    mb = mreset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; dest_addr = 2'd0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    fifo_full = 4'h0; fifo_empty = 4'hF; soft_reset = 4'h0;
    we_a = 0; we_b = 0; full_a = 0; busy_a = 0; n_wait = 0;
    ma = mreset();
    mb = mreset();
    #3;
    chk("reset_a_outputs", 32'(ov_a), 32'(outv(P_DEC)));
    chk("reset_a_drop_count", 32'(dc_a), 0);
    chk("reset_a_wait_timeout", 32'(wto_a), 0);
    chk("reset_b_outputs", 32'(ov_b), 32'(outv(P_DEC)));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();

    // Normal packet to port 2: DECODE, LFD, LD x3, LP, CPE, DECODE
    fifo_empty = 4'b0100; dest_addr = 2'd2; pkt_valid = 1'b1;
    tick();
    chk("norm_lfd", 32'(ov_a[B_LFD]), 1);
    we_a = 0;
    tick(); tick(); tick();
    pkt_valid = 1'b0;
    tick(); tick(); tick();
    chk("norm_we_cycles", we_a, 4);
    chk("norm_dest_sel", 32'(ds_a), 2);
    chk("norm_back_decode", 32'(ov_a[B_DA]), 1);

    // Full stall for five cycles, then resume and finish via low_pkt_valid
    pkt_valid = 1'b1;
    tick(); tick();
    fifo_full = 4'b0100;
    full_a = 0; we_a = 0; busy_a = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_full_cycles", full_a, 5);
    chk("stall_busy_cycles", busy_a, 5);
    chk("stall_no_write", we_a, 0);
    fifo_full = 4'h0;
    tick();
    chk("stall_laf", 32'(ov_a[B_LAF]), 1);
    low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    tick();
    chk("stall_to_parity", 32'(ov_a), 32'(outv(P_LP)));
    low_pkt_valid = 1'b0;
    tick(); tick();

    // Isolation: only the latched port's full/soft_reset matter
    dest_addr = 2'd1; fifo_empty = 4'b0010; pkt_valid = 1'b1;
    tick(); tick();
    fifo_full = 4'b1000; soft_reset = 4'b0001;
    tick();
    chk("iso_other_ports_1", 32'(ov_a[B_LD]), 1);
    tick();
    chk("iso_other_ports_2", 32'(ov_a[B_LD]), 1);
    fifo_full = 4'h0; soft_reset = 4'b0010;
    tick();
    chk("iso_own_soft_reset", 32'(ov_a[B_DA]), 1);
    soft_reset = 4'h0; pkt_valid = 1'b0;
    tick();

    // Wait-till-empty timeout on port 1
    fifo_empty = 4'h0; dest_addr = 2'd1; pkt_valid = 1'b1;
    tick();
    n_wait = 0;
    for (int i = 0; i < 20 && ov_a === outv(P_WAIT); i++) begin
      n_wait++;
      tick();
    end
    chk("to_wait_cycles", n_wait, 8);
    chk("to_in_drop", 32'(ov_a), 32'(outv(P_DROP)));
    chk("to_pulse_high", 32'(wto_a), 1);
    chk("to_drop_count", 32'(dc_a), 1);
    tick();
    chk("to_pulse_single", 32'(wto_a), 0);
    pkt_valid = 1'b0;
    tick();
    chk("to_exit_drop", 32'(ov_a[B_DA]), 1);

    // Invalid address on the 3-port instance, then saturate its 2-bit drop counter
    fifo_empty = 4'hF; dest_addr = 2'd3; pkt_valid = 1'b1; we_b = 0;
    tick();
    chk("inv_drop_b", 32'(ov_b), 32'(outv(P_DROP)));
    chk("inv_dest_sel_b", 32'(ds_b), 3);
    tick(); tick();
    pkt_valid = 1'b0;
    tick();
    chk("inv_exit_b", 32'(ov_b[B_DA]), 1);
    chk("inv_count_b", 32'(dc_b), 2);
    for (int i = 0; i < 3; i++) begin
      pkt_valid = 1'b1;
      tick();
      pkt_valid = 1'b0;
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
    chk("inv_no_write_b", we_b, 0);
    chk("sat_count_b", 32'(dc_b), 3);
    chk("valid_port3_a_count", 32'(dc_a), 1);

    // Asynchronous reset in the middle of LOAD_DATA
    dest_addr = 2'd0; pkt_valid = 1'b1;
    tick(); tick();
    chk("pre_reset_ld", 32'(ov_a), 32'(outv(P_LD)));
    async_reset("midld_reset");
    pkt_valid = 1'b0;
    tick();

    // Randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      dest_addr     = 2'($urandom_range(0, 3));
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = 1'($urandom_range(0, 1));
      fifo_empty    = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) begin
        fifo_full[b]  = ($urandom_range(0, 5) == 0);
        soft_reset[b] = ($urandom_range(0, 24) == 0);
      end
      if ($urandom_range(0, 299) == 0) async_reset("rand_reset");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
